// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
// The baud divider is derived from real-valued clock and line rates.
package uart_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    function automatic int clks_per_bit(input real sysclk, input real baud);
        return int'(sysclk / baud);
    endfunction

    // Code 3 is reserved on the configuration port and behaves like no parity.
    function automatic parity_e decode_parity(input logic [1:0] raw);
        case (raw)
            2'd1:    return EVEN;
            2'd2:    return ODD;
            default: return NONE;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: rdata always presents the oldest entry.
// Push when full and pop when empty are ignored.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: the storage array has no reset; pointers and level alone say which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed from an internal FIFO; frames go out back-to-back.
// Parity and stop-bit count are sampled when a word leaves the FIFO.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  real SYSCLOCK   = 27.0,
    parameter  real BAUDRATE   = 1.0,
    parameter  int  DATA_BITS  = 8,
    parameter  int  FIFO_DEPTH = 16,
    localparam int  LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    input  logic [DATA_BITS-1:0] s_data,
    output logic                 s_ready,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    output logic                 tx,
    output logic                 tx_bsy,
    output logic                 tx_done,
    output logic [LVL_W-1:0]     fifo_level
);

    localparam int CLKS_PER_BIT = clks_per_bit(SYSCLOCK, BAUDRATE);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
        $error("uart_tx_fifo: DATA_BITS must be within 5..9");
    end

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;

    tx_state_e            state_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 stop_phase_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_en_q;
    logic                 par_bit_q;
    logic                 stop2_q;
    logic                 tx_q;
    logic                 tx_bsy_q;
    logic                 tx_done_q;
    logic                 alive_q;

    parity_e              par_cfg;
    logic                 bit_end;
    logic                 stop_end;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (s_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign par_cfg   = decode_parity(cfg_parity);
    assign s_ready   = alive_q && !fifo_full;
    assign fifo_push = s_valid && s_ready;
    assign bit_end   = (bit_cnt_q == BIT_LAST);
    assign stop_end  = (state_q == STOP) && bit_end && (!stop2_q || stop_phase_q);

    // NOTE: pop is combinational so the popped word and the START transition share one edge.
    assign fifo_pop  = !fifo_empty && ((state_q == IDLE) || stop_end);

    assign tx      = tx_q;
    assign tx_bsy  = tx_bsy_q;
    assign tx_done = tx_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            idx_q        <= '0;
            stop_phase_q <= 1'b0;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            par_bit_q    <= 1'b0;
            stop2_q      <= 1'b0;
            tx_q         <= 1'b1;
            tx_bsy_q     <= 1'b0;
            tx_done_q    <= 1'b0;
            alive_q      <= 1'b0;
        end else begin
            alive_q   <= 1'b1;
            tx_done_q <= 1'b0;
            if (fifo_pop) begin
                state_q      <= START;
                bit_cnt_q    <= '0;
                idx_q        <= '0;
                stop_phase_q <= 1'b0;
                shift_q      <= fifo_rdata;
                par_en_q     <= (par_cfg != NONE);
                par_bit_q    <= (par_cfg == ODD) ? ~^fifo_rdata : ^fifo_rdata;
                stop2_q      <= cfg_stop2;
                tx_q         <= 1'b0;
                tx_bsy_q     <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        tx_q     <= 1'b1;
                        tx_bsy_q <= 1'b0;
                    end
                    START: begin
                        if (bit_end) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                            tx_q      <= shift_q[0];
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            bit_cnt_q <= '0;
                            if (idx_q == IDX_LAST) begin
                                idx_q <= '0;
                                if (par_en_q) begin
                                    state_q <= PARITY;
                                    tx_q    <= par_bit_q;
                                end else begin
                                    state_q <= STOP;
                                    tx_q    <= 1'b1;
                                end
                            end else begin
                                idx_q   <= idx_q + IDX_W'(1);
                                shift_q <= shift_q >> 1;
                                tx_q    <= shift_q[1];
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                    PARITY: begin
                        if (bit_end) begin
                            state_q   <= STOP;
                            bit_cnt_q <= '0;
                            tx_q      <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                    STOP: begin
                        if (bit_end) begin
                            bit_cnt_q <= '0;
                            if (stop_end) begin
                                state_q      <= IDLE;
                                stop_phase_q <= 1'b0;
                                tx_bsy_q     <= 1'b0;
                            end else begin
                                stop_phase_q <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            // Registered pulse: raise it one cycle early so it lands on the last stop cycle.
                            tx_done_q <= (bit_cnt_q == DONE_CNT) && (!stop2_q || stop_phase_q);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
